// File: rtl/say_arb_pkg.sv
// Shared types and constants for the say-method round-robin arbiter.
// Holds the payload layout, index-width helper and reset values.
package say_arb_pkg;

    localparam int unsigned NREQ_MAX   = 8;
    localparam int unsigned SAY_DATA_W = 192;
    localparam int unsigned CNT_W_DEF  = 16;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [SAY_DATA_W-1:0] meth;
        logic [SAY_DATA_W-1:0] v;
    } say_payload_t;

    localparam logic         RST_FULL    = 1'b0;
    localparam say_payload_t RST_PAYLOAD = '0;

endpackage

// File: rtl/say_rr_arbiter_if.sv
// Requester-side and downstream-side ENA/RDY signals of the say arbiter.
// master = clients plus downstream consumer, slave = the arbiter.
interface say_rr_arbiter_if
    import say_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = SAY_DATA_W,
    parameter int unsigned IW     = idx_w(NREQ)
);

    logic [NREQ-1:0]        req_want;
    logic [NREQ-1:0]        req__ENA;
    logic [NREQ*DATA_W-1:0] req_meth;
    logic [NREQ*DATA_W-1:0] req_v;
    logic [NREQ-1:0]        req__RDY;

    logic                   say__ENA;
    logic [DATA_W-1:0]      say_meth;
    logic [DATA_W-1:0]      say_v;
    logic [IW-1:0]          say_src;
    logic                   say__RDY;

    modport master (
        output req_want,
        output req__ENA,
        output req_meth,
        output req_v,
        input  req__RDY,
        input  say__ENA,
        input  say_meth,
        input  say_v,
        input  say_src,
        output say__RDY
    );

    modport slave (
        input  req_want,
        input  req__ENA,
        input  req_meth,
        input  req_v,
        output req__RDY,
        output say__ENA,
        output say_meth,
        output say_v,
        output say_src,
        input  say__RDY
    );

endinterface

// File: rtl/say_rr_arbiter_rr_pick.sv
// Round-robin pick: first wanting requester at or after ptr, wrapping modulo NREQ.
// Purely combinational; returns one-hot grant, its index and a valid flag.
module rr_pick
    import say_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] want,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [IW-1:0] cand;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!grant_vld && want[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/say_rr_arbiter.sv
// Round-robin arbiter sharing one say method among NREQ requesters, with a
// one-entry registered output stage and per-requester accept counters.
module say_rr_arbiter
    import say_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = SAY_DATA_W,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned IW     = idx_w(NREQ)
) (
    input  logic             CLK,
    input  logic             nRST,
    say_rr_arbiter_if.slave  arb,
    input  logic [IW-1:0]    stat_sel,
    output logic [CNT_W-1:0] stat_count
);

    typedef struct packed {
        logic [DATA_W-1:0] meth;
        logic [DATA_W-1:0] v;
    } payload_t;

    logic             full_q;
    payload_t         hold_q;
    logic [IW-1:0]    src_q;
    logic [IW-1:0]    ptr_q;
    logic [CNT_W-1:0] cnt_q [NREQ];

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_vld;
    logic             can_acc;
    logic [NREQ-1:0]  rdy;
    logic             accept;
    logic [IW-1:0]    ptr_nxt;
    payload_t         sel_pl;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .want      (arb.req_want),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // A slot is free when empty or when the held entry leaves this cycle.
    assign can_acc = !full_q || arb.say__RDY;
    assign rdy     = (nRST && can_acc && grant_vld) ? grant : '0;
    assign accept  = |(arb.req__ENA & rdy);
    assign ptr_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);

    // Payload of the granted requester; only that slice may ever load.
    always_comb begin
        sel_pl = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_pl.meth = arb.req_meth[i*DATA_W +: DATA_W];
                sel_pl.v    = arb.req_v[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage and rotation pointer; accept wins over dequeue so a
    // simultaneous dequeue/accept reloads without a bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full_q <= RST_FULL;
            hold_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            hold_q <= sel_pl;
            src_q  <= grant_idx;
            ptr_q  <= ptr_nxt;
        end else if (full_q && arb.say__RDY) begin
            full_q <= 1'b0;
        end
    end

    // Accept counters wrap naturally at 2^CNT_W.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept && grant[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        stat_count = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(stat_sel) == i) begin
                stat_count = cnt_q[i];
            end
        end
    end

    assign arb.req__RDY = rdy;
    assign arb.say__ENA = full_q;
    assign arb.say_meth = hold_q.meth;
    assign arb.say_v    = hold_q.v;
    assign arb.say_src  = src_q;

    a_ena_legal: assert property (@(posedge CLK) disable iff (!nRST)
        (arb.req__ENA & ~arb.req__RDY) == '0)
        else $error("say_rr_arbiter: req__ENA asserted without req__RDY");

    a_rdy_onehot: assert property (@(posedge CLK) disable iff (!nRST)
        $onehot0(arb.req__RDY))
        else $error("say_rr_arbiter: req__RDY not one-hot");

endmodule

// File: tb/tb_say_rr_arbiter.sv
// Randomized scoreboard bench for say_rr_arbiter with a rotation-order reference model.
module tb_say_rr_arbiter;
    import say_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 192;
    localparam int unsigned CW   = 16;
    localparam int unsigned IW   = 2;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [IW-1:0] stat_sel;
    logic [CW-1:0] stat_count;

    always #5 CLK = ~CLK;

    say_rr_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) arb_if ();

    say_rr_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .arb        (arb_if),
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
    );

    typedef struct packed {
        say_payload_t  pl;
        logic [IW-1:0] src;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Reference model state
    bit          m_full;
    int          m_ptr;
    int unsigned m_cnt [NREQ];
    bit          fixed_en = 1'b0;
    logic [DW-1:0] fixed_meth = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Rotation rule: first wanting requester starting at ptr, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] want, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (want[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        sb_q.delete();
    endtask

    // One cycle: drive, check RDY/stat, commit the model at the edge.
    task automatic step(input logic [NREQ-1:0] want, input logic [NREQ-1:0] fire, input logic dn_rdy);
        int              g;
        bit              can_acc;
        logic [NREQ-1:0] exp_rdy;
        logic [IW-1:0]   sel;
        exp_t            e;
        arb_if.req_want = want;
        arb_if.say__RDY = dn_rdy;
        for (int i = 0; i < NREQ; i++) begin
            arb_if.req_meth[i*DW +: DW] = fixed_en ? fixed_meth : rnd_word();
            arb_if.req_v[i*DW +: DW]    = rnd_word();
        end
        sel      = IW'($urandom_range(NREQ - 1));
        stat_sel = sel;
        can_acc  = !m_full || dn_rdy;
        g        = pick(want, m_ptr);
        exp_rdy  = (can_acc && g >= 0) ? (NREQ'(1) << g) : '0;
        arb_if.req__ENA = (g >= 0 && fire[g]) ? exp_rdy : '0;
        e = '0;
        if (g >= 0) begin
            e.pl.meth = arb_if.req_meth[g*DW +: DW];
            e.pl.v    = arb_if.req_v[g*DW +: DW];
            e.src     = IW'(g);
        end
        #1;
        check("req_rdy", DW'(arb_if.req__RDY), DW'(exp_rdy));
        check("stat_count", DW'(stat_count), DW'(m_cnt[sel]));
        @(posedge CLK);
        if (arb_if.req__ENA != '0) begin
            sb_q.push_back(e);
            m_cnt[g] = (m_cnt[g] + 1) % (1 << CW);
            m_ptr    = (g + 1) % NREQ;
            m_full   = 1'b1;
        end else if (dn_rdy) begin
            m_full = 1'b0;
        end
        #2;
    endtask

    // Monitor: compares the held entry every cycle, pops on downstream accept.
    initial begin
        forever begin
            @(negedge CLK);
            if (sb_q.size() == 0) begin
                check("say_ena_idle", DW'(arb_if.say__ENA), DW'(0));
            end else begin
                check("say_ena", DW'(arb_if.say__ENA), DW'(1));
                check("say_meth", arb_if.say_meth, sb_q[0].pl.meth);
                check("say_v", arb_if.say_v, sb_q[0].pl.v);
                check("say_src", DW'(arb_if.say_src), DW'(sb_q[0].src));
                if (arb_if.say__RDY) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        nRST            = 1'b0;
        stat_sel        = '0;
        arb_if.req_want = 4'hF;
        arb_if.req__ENA = 4'hF;
        arb_if.req_meth = '0;
        arb_if.req_v    = '0;
        arb_if.say__RDY = 1'b1;
        model_reset();

        // Reset: nothing granted, nothing held, counters zero.
        repeat (2) @(posedge CLK);
        #2;
        check("rst_req_rdy", DW'(arb_if.req__RDY), DW'(0));
        check("rst_say_ena", DW'(arb_if.say__ENA), DW'(0));
        check("rst_say_meth", arb_if.say_meth, DW'(0));
        check("rst_say_src", DW'(arb_if.say_src), DW'(0));
        check("rst_stat", DW'(stat_count), DW'(0));
        nRST = 1'b1;
        step(4'hF, 4'h0, 1'b1);

        // Rotation, full throughput.
        repeat (5) step(4'hF, 4'hF, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        for (int s = 0; s < NREQ; s++) begin
            stat_sel = IW'(s);
            #1;
            check("rot_stat", DW'(stat_count), DW'(m_cnt[s]));
        end

        // Stall with a fixed payload, then same-cycle reload from requester 3.
        fixed_en   = 1'b1;
        fixed_meth = 192'hA5;
        step(4'b0100, 4'hF, 1'b1);
        repeat (5) step(4'hF, 4'hF, 1'b0);
        step(4'b1000, 4'hF, 1'b1);
        fixed_en = 1'b0;
        step(4'h0, 4'h0, 1'b1);

        // Skip over idle requesters in both directions.
        step(4'b0001, 4'hF, 1'b1);
        step(4'b1001, 4'hF, 1'b1);
        step(4'b1001, 4'hF, 1'b1);
        step(4'h0, 4'h0, 1'b1);

        // Randomized traffic with backpressure.
        repeat (400) step(4'($urandom), 4'($urandom), 1'($urandom_range(3) != 0));
        step(4'h0, 4'h0, 1'b1);

        // Async reset between edges while stalled full.
        step(4'hF, 4'hF, 1'b1);
        step(4'hF, 4'hF, 1'b0);
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        check("arst_say_ena", DW'(arb_if.say__ENA), DW'(0));
        check("arst_req_rdy", DW'(arb_if.req__RDY), DW'(0));
        arb_if.req_want = 4'hF;
        arb_if.req__ENA = 4'hF;
        arb_if.say__RDY = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        check("arst_hold_ena", DW'(arb_if.say__ENA), DW'(0));
        check("arst_hold_stat", DW'(stat_count), DW'(0));
        nRST = 1'b1;
        repeat (2) step(4'h0, 4'h0, 1'b1);

        // Counter wrap on requester 1.
        repeat (65535) step(4'b0010, 4'hF, 1'b1);
        stat_sel = 2'd1;
        #1;
        check("wrap_max", DW'(stat_count), DW'(16'hFFFF));
        step(4'b0010, 4'hF, 1'b1);
        stat_sel = 2'd1;
        #1;
        check("wrap_zero", DW'(stat_count), DW'(0));
        step(4'h0, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        check("sb_drained", DW'(sb_q.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
